// File: rtl/swc_rtu_rsp_demux_if.sv
// -----------------------------------------------------------------------------
// swc_rtu_rsp_demux_if
// Bundle of the RTU decision stream (engine side) and the per-port RTU
// response outputs (swc core side) handled by swc_rtu_rsp_demux.
//
// Handshake semantics (both directions):
//   A transfer happens on a rising clk edge when the producer's valid and the
//   consumer's ready/ack are both high. A producer holds its valid and its data
//   stable until the transfer happens. A consumer may raise ready/ack at any
//   time, including while valid is low; in that case nothing is transferred.
//
// Signals:
//   req_valid_i / req_ready_o      engine decision handshake
//   req_port_i                     ingress port index of the decision
//   req_mask_i, req_drop_i, req_prio_i  decision payload
//   req_err_o                      one-cycle pulse: decision discarded, bad index
//   rtu_rsp_valid_o / rtu_rsp_ack_i  per-port head valid / pop
//   rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o  per-port head payload (flat)
//   fifo_full_o                    per-port queue full
//
// Modports: slave = the demux itself, master = engine plus swc core.
// -----------------------------------------------------------------------------
interface swc_rtu_rsp_demux_if #(
   parameter int g_num_ports      = 7,
   parameter int g_prio_width     = 3,
   parameter int g_port_idx_width = 3
);
   logic                                 req_valid_i;
   logic                                 req_ready_o;
   logic [g_port_idx_width-1:0]          req_port_i;
   logic [g_num_ports-1:0]               req_mask_i;
   logic                                 req_drop_i;
   logic [g_prio_width-1:0]              req_prio_i;
   logic                                 req_err_o;
   logic [g_num_ports-1:0]               rtu_rsp_valid_o;
   logic [g_num_ports-1:0]               rtu_rsp_ack_i;
   logic [g_num_ports*g_num_ports-1:0]   rtu_dst_port_mask_o;
   logic [g_num_ports-1:0]               rtu_drop_o;
   logic [g_num_ports*g_prio_width-1:0]  rtu_prio_o;
   logic [g_num_ports-1:0]               fifo_full_o;

   modport slave (
      input  req_valid_i, req_port_i, req_mask_i, req_drop_i, req_prio_i,
      input  rtu_rsp_ack_i,
      output req_ready_o, req_err_o,
      output rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o,
      output fifo_full_o
   );

   modport master (
      output req_valid_i, req_port_i, req_mask_i, req_drop_i, req_prio_i,
      output rtu_rsp_ack_i,
      input  req_ready_o, req_err_o,
      input  rtu_rsp_valid_o, rtu_dst_port_mask_o, rtu_drop_o, rtu_prio_o,
      input  fifo_full_o
   );
endinterface

// File: rtl/swc_rtu_rsp_demux.sv
// -----------------------------------------------------------------------------
// swc_rtu_rsp_demux
// Splits the serialized RTU decision stream into g_num_ports independent
// show-ahead FIFOs so that a stalled swc port never blocks the others.
//
// Ports:
//   clk_i    system clock
//   rst_n_i  synchronous active-low reset
//   bus      swc_rtu_rsp_demux_if.slave (decision input, per-port responses)
//
// A decision accepted at edge k is visible at the queue head from cycle k+1;
// there is no same-cycle pass-through. Head outputs read as zero while their
// queue is empty.
// -----------------------------------------------------------------------------
module swc_rtu_rsp_demux #(
   parameter int g_num_ports      = 7,
   parameter int g_prio_width     = 3,
   parameter int g_port_idx_width = 3,
   parameter int g_fifo_depth     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   swc_rtu_rsp_demux_if.slave   bus
);

   localparam int PW = $clog2(g_fifo_depth);
   localparam int CW = PW + 1;
   localparam int N  = g_num_ports;
   localparam int W  = g_prio_width;

   // Per-port storage; contents are not reset because the outputs are gated
   // by the (reset) count.
   logic [N-1:0]  r_mask [N][g_fifo_depth];
   logic          r_drop [N][g_fifo_depth];
   logic [W-1:0]  r_prio [N][g_fifo_depth];

   logic [PW-1:0] r_wr_ptr [N];
   logic [PW-1:0] r_rd_ptr [N];
   logic [CW-1:0] r_count  [N];
   logic          r_err;

   logic [N-1:0]   w_push;
   logic [N-1:0]   w_pop;
   logic [N-1:0]   w_full;
   logic [N-1:0]   w_valid;
   logic           w_legal;
   logic           w_ready;
   logic           w_accept;
   logic [N*N-1:0] w_mask_out;
   logic [N-1:0]   w_drop_out;
   logic [N*W-1:0] w_prio_out;

   always_comb begin
      w_push     = '0;
      w_pop      = '0;
      w_full     = '0;
      w_valid    = '0;
      w_legal    = 1'b0;
      w_ready    = 1'b0;
      w_accept   = 1'b0;
      w_mask_out = '0;
      w_drop_out = '0;
      w_prio_out = '0;

      for (int p = 0; p < N; p++) begin
         w_full[p]  = (r_count[p] == CW'(g_fifo_depth));
         w_valid[p] = (r_count[p] != '0);
         // Acks against an empty queue are dropped here, so no underflow.
         w_pop[p]   = bus.rtu_rsp_ack_i[p] & w_valid[p];
         if (w_valid[p]) begin
            w_mask_out[p*N +: N] = r_mask[p][r_rd_ptr[p]];
            w_drop_out[p]        = r_drop[p][r_rd_ptr[p]];
            w_prio_out[p*W +: W] = r_prio[p][r_rd_ptr[p]];
         end
         // Ready looks only at the current full flag: a same-cycle pop does
         // not open a slot for the incoming decision.
         if (int'(bus.req_port_i) == p) begin
            w_legal = 1'b1;
            w_ready = ~w_full[p];
         end
      end

      // Out-of-range indices are always accepted so they can be discarded.
      if (!w_legal) w_ready = 1'b1;
      if (!rst_n_i) w_ready = 1'b0;

      w_accept = bus.req_valid_i & w_ready;

      for (int p = 0; p < N; p++) begin
         w_push[p] = w_accept & (int'(bus.req_port_i) == p);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int p = 0; p < N; p++) begin
            r_wr_ptr[p] <= '0;
            r_rd_ptr[p] <= '0;
            r_count[p]  <= '0;
         end
         r_err <= 1'b0;
      end else begin
         r_err <= w_accept & ~w_legal;
         for (int p = 0; p < N; p++) begin
            if (w_push[p]) begin
               r_mask[p][r_wr_ptr[p]] <= bus.req_mask_i;
               r_drop[p][r_wr_ptr[p]] <= bus.req_drop_i;
               r_prio[p][r_wr_ptr[p]] <= bus.req_prio_i;
               r_wr_ptr[p]            <= r_wr_ptr[p] + PW'(1);
            end
            if (w_pop[p]) begin
               r_rd_ptr[p] <= r_rd_ptr[p] + PW'(1);
            end
            case ({w_push[p], w_pop[p]})
               2'b10:   r_count[p] <= r_count[p] + CW'(1);
               2'b01:   r_count[p] <= r_count[p] - CW'(1);
               default: r_count[p] <= r_count[p];
            endcase
         end
      end
   end

   assign bus.req_ready_o         = w_ready;
   assign bus.req_err_o           = r_err;
   assign bus.rtu_rsp_valid_o     = w_valid;
   assign bus.fifo_full_o         = w_full;
   assign bus.rtu_dst_port_mask_o = w_mask_out;
   assign bus.rtu_drop_o          = w_drop_out;
   assign bus.rtu_prio_o          = w_prio_out;

endmodule

// File: tb/tb_swc_rtu_rsp_demux.sv
// -----------------------------------------------------------------------------
// tb_swc_rtu_rsp_demux
// Directed plus short random stimulus for swc_rtu_rsp_demux. A per-port
// expected queue tracks what every FIFO must hold; head outputs, valid, full,
// ready and the error pulse are compared every cycle against it.
// -----------------------------------------------------------------------------
module tb_swc_rtu_rsp_demux;

   localparam int N  = 7;
   localparam int W  = 3;
   localparam int IW = 3;
   localparam int D  = 4;
   localparam int EW = N + 1 + W;

   logic clk;
   logic rst_n;

   int vectors;
   int miscompares;

   // Expected contents per port, entry = {mask, drop, prio}.
   logic [EW-1:0] exp_q [N][$];

   swc_rtu_rsp_demux_if #(
      .g_num_ports(N), .g_prio_width(W), .g_port_idx_width(IW)
   ) bus ();

   swc_rtu_rsp_demux #(
      .g_num_ports(N), .g_prio_width(W), .g_port_idx_width(IW), .g_fifo_depth(D)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic v, input logic [IW-1:0] port,
                          input logic [N-1:0] mask, input logic drop,
                          input logic [W-1:0] prio);
      bus.req_valid_i = v;
      bus.req_port_i  = port;
      bus.req_mask_i  = mask;
      bus.req_drop_i  = drop;
      bus.req_prio_i  = prio;
   endtask

   task automatic idle();
      bus.req_valid_i = 1'b0;
   endtask

   task automatic check_outputs();
      logic [N-1:0]   e_valid;
      logic [N-1:0]   e_full;
      logic [N*N-1:0] e_mask;
      logic [N-1:0]   e_drop;
      logic [N*W-1:0] e_prio;
      logic [EW-1:0]  ent;
      e_valid = '0; e_full = '0; e_mask = '0; e_drop = '0; e_prio = '0;
      for (int p = 0; p < N; p++) begin
         if (exp_q[p].size() > 0) begin
            ent              = exp_q[p][0];
            e_valid[p]       = 1'b1;
            e_mask[p*N +: N] = ent[EW-1 -: N];
            e_drop[p]        = ent[W];
            e_prio[p*W +: W] = ent[W-1:0];
         end
         e_full[p] = (exp_q[p].size() == D);
      end
      check("rsp_valid", bus.rtu_rsp_valid_o, e_valid);
      check("fifo_full", bus.fifo_full_o, e_full);
      check("dst_mask", bus.rtu_dst_port_mask_o, e_mask);
      check("drop", bus.rtu_drop_o, e_drop);
      check("prio", bus.rtu_prio_o, e_prio);
   endtask

   // One clock: checks ready before the edge, updates the model with the
   // inputs as driven, then checks registered outputs after the edge.
   task automatic step();
      logic legal;
      logic rdy_exp;
      logic acc;
      logic err_exp;
      int   port;
      #1;
      port  = int'(bus.req_port_i);
      legal = (port < N);
      if (!rst_n)     rdy_exp = 1'b0;
      else if (!legal) rdy_exp = 1'b1;
      else            rdy_exp = (exp_q[port].size() < D);
      check("req_ready", bus.req_ready_o, rdy_exp);
      acc = bus.req_valid_i & rdy_exp;
      if (!rst_n) begin
         for (int p = 0; p < N; p++) exp_q[p].delete();
         err_exp = 1'b0;
      end else begin
         for (int p = 0; p < N; p++) begin
            if (bus.rtu_rsp_ack_i[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
         end
         if (acc && legal)
            exp_q[port].push_back({bus.req_mask_i, bus.req_drop_i, bus.req_prio_i});
         err_exp = acc & ~legal;
      end
      @(posedge clk);
      #1;
      check("req_err", bus.req_err_o, err_exp);
      check_outputs();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      bus.rtu_rsp_ack_i = '0;
      set_req(1'b0, '0, '0, 1'b0, '0);

      // Reset state
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: single decision to port 2, then ack
      set_req(1'b1, 3'd2, 7'b0010001, 1'b0, 3'd5);
      step();
      idle();
      check("t1_valid", bus.rtu_rsp_valid_o, 7'b0000100);
      check("t1_mask2", bus.rtu_dst_port_mask_o[2*N +: N], 7'b0010001);
      check("t1_prio2", bus.rtu_prio_o[2*W +: W], 3'd5);
      bus.rtu_rsp_ack_i = 7'b0000100;
      step();
      bus.rtu_rsp_ack_i = '0;
      check("t1_valid_clr", bus.rtu_rsp_valid_o, 7'b0000000);

      // 2: fill port 0, fifth decision stalls, port 3 still accepted
      for (int i = 1; i <= 4; i++) begin
         set_req(1'b1, 3'd0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), W'(i));
         step();
      end
      check("t2_full0", bus.fifo_full_o[0], 1'b1);
      set_req(1'b1, 3'd0, 7'($urandom_range(0, 127)), 1'b0, 3'd5);
      #1;
      check("t2_ready_full", bus.req_ready_o, 1'b0);
      step();
      set_req(1'b1, 3'd3, 7'($urandom_range(0, 127)), 1'b1, 3'd7);
      #1;
      check("t2_ready_p3", bus.req_ready_o, 1'b1);
      step();

      // 3: full port 0 with ack and request in the same cycle -> no bypass
      set_req(1'b1, 3'd0, 7'b1010101, 1'b1, 3'd5);
      bus.rtu_rsp_ack_i = 7'b0000001;
      #1;
      check("t3_ready_nobypass", bus.req_ready_o, 1'b0);
      step();
      bus.rtu_rsp_ack_i = '0;
      check("t3_not_full", bus.fifo_full_o[0], 1'b0);
      step();
      idle();
      check("t3_full_again", bus.fifo_full_o[0], 1'b1);
      bus.rtu_rsp_ack_i = 7'b0001001;
      step();
      bus.rtu_rsp_ack_i = 7'b0000001;
      for (int i = 0; i < 4; i++) step();
      bus.rtu_rsp_ack_i = '0;
      check("t3_drained", bus.rtu_rsp_valid_o, 7'b0000000);

      // 4: count 1 on port 1, simultaneous push and ack
      set_req(1'b1, 3'd1, 7'b0000011, 1'b0, 3'd2);
      step();
      set_req(1'b1, 3'd1, 7'b1100000, 1'b1, 3'd6);
      bus.rtu_rsp_ack_i = 7'b0000010;
      step();
      idle();
      bus.rtu_rsp_ack_i = '0;
      check("t4_valid1", bus.rtu_rsp_valid_o[1], 1'b1);
      check("t4_prio1", bus.rtu_prio_o[1*W +: W], 3'd6);
      bus.rtu_rsp_ack_i = 7'b0000010;
      step();
      bus.rtu_rsp_ack_i = '0;

      // 5: illegal port index, then ack on an empty queue
      set_req(1'b1, 3'd7, 7'b1111111, 1'b1, 3'd1);
      #1;
      check("t5_ready_illegal", bus.req_ready_o, 1'b1);
      step();
      idle();
      check("t5_err_pulse", bus.req_err_o, 1'b1);
      step();
      check("t5_err_clr", bus.req_err_o, 1'b0);
      bus.rtu_rsp_ack_i = 7'b0010000;
      step();
      bus.rtu_rsp_ack_i = '0;
      step();

      // 6: fill every port with two entries, reset mid-operation
      for (int p = 0; p < N; p++) begin
         for (int k = 0; k < 2; k++) begin
            set_req(1'b1, IW'(p), 7'($urandom_range(1, 127)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)));
            step();
         end
      end
      idle();
      rst_n = 1'b0;
      bus.rtu_rsp_ack_i = 7'($urandom_range(0, 127));
      step();
      rst_n = 1'b1;
      bus.rtu_rsp_ack_i = '0;
      check("t6_valid_rst", bus.rtu_rsp_valid_o, 7'b0000000);
      check("t6_full_rst", bus.fifo_full_o, 7'b0000000);
      check("t6_mask_rst", bus.rtu_dst_port_mask_o, 49'd0);
      set_req(1'b1, 3'd5, 7'b0100100, 1'b0, 3'd3);
      step();
      idle();
      check("t6_latency", bus.rtu_rsp_valid_o, 7'b0100000);

      // Random traffic, then drain
      for (int i = 0; i < 80; i++) begin
         set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
         bus.rtu_rsp_ack_i = 7'($urandom_range(0, 127));
         step();
      end
      idle();
      bus.rtu_rsp_ack_i = 7'b1111111;
      for (int i = 0; i < D + 1; i++) step();
      bus.rtu_rsp_ack_i = '0;
      check("final_empty", bus.rtu_rsp_valid_o, 7'b0000000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/swc_rtu_rsp_demux.md
Name: swc_rtu_rsp_demux

Overview:
- Sits between the shared RTU lookup engine and the swc core's per-port RTU response inputs (rsp_valid / ack / dst_port_mask / drop / prio).
- The RTU engine produces one serialized decision stream tagged with an ingress port index.
- This block demultiplexes that stream into g_num_ports independent show-ahead FIFOs.
- Each FIFO head is presented to the swc core with a per-port valid/ack handshake, so a stalled port never blocks decisions for other ports.

Parameters:
- g_num_ports, 7: number of switch ports and per-port queues.
- g_prio_width, 3: width of the priority field.
- g_port_idx_width, 3: width of the ingress port index; must satisfy 2**g_port_idx_width >= g_num_ports.
- g_fifo_depth, 4: entries per port queue; power of two, >= 2.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  RTU engine presents a decision.
- req_ready_o  out  1  decision accepted this cycle when high together with req_valid_i.
- req_port_i  in  g_port_idx_width  ingress port the decision belongs to.
- req_mask_i  in  g_num_ports  destination port mask.
- req_drop_i  in  1  drop flag.
- req_prio_i  in  g_prio_width  frame priority.
- req_err_o  out  1  one-cycle pulse when a decision with an illegal port index is discarded.
- rtu_rsp_valid_o  out  g_num_ports  bit p high when queue p is non-empty.
- rtu_rsp_ack_i  in  g_num_ports  bit p pops the head of queue p.
- rtu_dst_port_mask_o  out  g_num_ports*g_num_ports  head mask of port p at bits [p*N+N-1 : p*N].
- rtu_drop_o  out  g_num_ports  head drop flag per port.
- rtu_prio_o  out  g_num_ports*g_prio_width  head prio of port p at bits [p*W+W-1 : p*W].
- fifo_full_o  out  g_num_ports  queue p full.

Behaviour:
- One clock (clk_i). Reset is synchronous, active-low (rst_n_i sampled on the rising edge of clk_i).
- Reset values:
  - All queue pointers and counts are 0.
  - rtu_rsp_valid_o = 0, fifo_full_o = 0, req_err_o = 0.
  - rtu_dst_port_mask_o, rtu_drop_o and rtu_prio_o are driven to 0 while their queue is empty.
- req_ready_o (combinational):
  - low during reset;
  - otherwise high if req_port_i >= g_num_ports;
  - otherwise the inverse of fifo_full_o[req_port_i].
  - A full queue deasserts ready even if the same port is acked in the same cycle (no full-bypass).
- Accept = req_valid_i & req_ready_o.
  - Legal index: {mask, drop, prio} is written at the queue p tail and the count increments on the same edge.
  - Illegal index: the decision is discarded and req_err_o pulses high for exactly the following cycle.
- Latency: a decision accepted at edge k into an empty queue makes rtu_rsp_valid_o[p] high after edge k. The swc core sees it in cycle k+1. No same-cycle pass-through.
- Show-ahead outputs:
  - Head data is stable while rtu_rsp_valid_o[p] is high and not acked.
  - rtu_rsp_ack_i[p] while valid pops one entry at the edge; the next entry, if present, is presented the following cycle.
  - Ack while the queue is empty is ignored: no underflow, no pointer change.
- Simultaneous push and pop on the same non-full queue: count is unchanged; the new entry goes to the tail and the old head leaves. If count was 1, valid stays high and the head becomes the new entry.
- Pointers are log2(g_fifo_depth) bits and wrap modulo depth. Count is log2(g_fifo_depth)+1 bits. full = (count == g_fifo_depth); empty = (count == 0).
- Per-port ordering is strict FIFO. There is no ordering relation between different ports.
- Reset asserted mid-operation: all queued entries are lost, outputs return to reset values on the next edge, and pending acks are ignored.
- Storage is per-port registers or one distributed RAM per port; no cross-port arbitration is needed because only one write occurs per cycle.

Test Plan:
1. Reset, then a single decision with port=2, mask=7'b0010001, drop=0, prio=5 -> next cycle rtu_rsp_valid_o=7'b0000100, port-2 mask slice=7'b0010001, prio slice=5. Ack port 2 -> valid returns to 0 the next cycle.
2. Push 4 decisions to port 0 with no ack -> fifo_full_o[0]=1. A fifth decision to port 0 sees req_ready_o=0. A decision to port 3 in the following cycle is accepted (ready=1).
3. Full port 0 with ack[0] and a port-0 request in the same cycle -> request stalled, count drops to 3. The request is accepted the next cycle and entries pop in order 1,2,3,4,5.
4. Count=1 on port 1 with simultaneous push (prio=6) and ack -> valid[1] stays 1, head prio becomes 6, count stays 1.
5. req_port_i=7 with valid -> req_ready_o=1, no queue changes, req_err_o high for exactly one cycle. ack[4] on an empty queue -> no change.
6. Fill ports 0-6 with 2 entries each, assert rst_n_i=0 for one cycle -> all rtu_rsp_valid_o=0, fifo_full_o=0, outputs 0. A fresh push afterwards appears with 1-cycle latency.
